// File: rtl/serdes_pkg.sv
// Shared widths, sync headers and frame types for the SerDes coder.
// Frames are a sync header followed by the payload, sent MSB first.
package serdes_pkg;
    localparam int DATA_W  = 32;
    localparam int SYNC_W  = 2;
    localparam int FRAME_W = SYNC_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W);

    localparam logic [SYNC_W-1:0] SYNC_DATA = 2'b01;
    localparam logic [SYNC_W-1:0] SYNC_IDLE = 2'b10;
    localparam logic [DATA_W-1:0] IDLE_WORD = 32'h0000_0000;

    typedef logic [DATA_W-1:0]  word_t;
    typedef logic [FRAME_W-1:0] frame_t;
    typedef logic [CNT_W-1:0]   cnt_t;

    localparam cnt_t CNT_LAST = cnt_t'(FRAME_W - 1);

    // An idle frame ignores the payload argument entirely.
    function automatic frame_t build_frame(input logic is_data, input word_t payload);
        return is_data ? {SYNC_DATA, payload} : {SYNC_IDLE, IDLE_WORD};
    endfunction
endpackage

// File: rtl/tx_hold_buf.sv
// One-entry hold register between the word source and the serializer.
// It drains at every frame boundary and may refill in that same cycle.
module tx_hold_buf
    import serdes_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              boundary,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic [DATA_W-1:0] hold_q,
    output logic              hold_vld
);
    logic accept;

    assign s_ready = !rst && (!hold_vld || boundary);
    assign accept  = s_valid && s_ready;

    // A refill on the boundary wins over the drain, so the buffer stays full.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q   <= '0;
            hold_vld <= 1'b0;
        end else if (accept) begin
            hold_q   <= s_data;
            hold_vld <= 1'b1;
        end else if (boundary) begin
            hold_vld <= 1'b0;
        end
    end
endmodule

// File: rtl/tx_ser.sv
// TX parallel-to-serial stage: emits a continuous stream of sync-headed
// frames, one bit per bit_en strobe, idle frames whenever no word is held.
module tx_ser
    import serdes_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_en,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ser_out,
    output logic              frame_start,
    output logic              frame_is_data,
    output logic              underrun
);
    cnt_t   bit_cnt;
    frame_t shreg;
    frame_t next_frame;
    word_t  hold_q;
    logic   hold_vld;
    logic   boundary;

    assign boundary   = bit_en && (bit_cnt == '0);
    assign next_frame = build_frame(hold_vld, hold_q);

    tx_hold_buf u_hold (
        .clk      (clk),
        .rst      (rst),
        .boundary (boundary),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_ready  (s_ready),
        .hold_q   (hold_q),
        .hold_vld (hold_vld)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0;
        end else if (bit_en) begin
            bit_cnt <= (bit_cnt == CNT_LAST) ? '0 : bit_cnt + cnt_t'(1);
        end
    end

    // The frame MSB goes straight to ser_out on load; the shift register keeps the rest.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg         <= '0;
            ser_out       <= 1'b0;
            frame_start   <= 1'b0;
            frame_is_data <= 1'b0;
            underrun      <= 1'b0;
        end else if (boundary) begin
            ser_out       <= next_frame[FRAME_W-1];
            shreg         <= {next_frame[FRAME_W-2:0], 1'b0};
            frame_start   <= 1'b1;
            frame_is_data <= hold_vld;
            underrun      <= !hold_vld;
        end else if (bit_en) begin
            ser_out       <= shreg[FRAME_W-1];
            shreg         <= {shreg[FRAME_W-2:0], 1'b0};
            frame_start   <= 1'b0;
            underrun      <= 1'b0;
        end else begin
            frame_start   <= 1'b0;
            underrun      <= 1'b0;
        end
    end
endmodule

// File: tb/tb_tx_ser.sv
// Self-checking bench for tx_ser: a fixed vector table, directed multi-cycle
// sequences and a random run, all checked against a frame-level reference model.
module tb_tx_ser;
    import serdes_pkg::*;

    logic  clk = 1'b0;
    logic  rst = 1'b1, bit_en = 1'b0, s_valid = 1'b0;
    word_t s_data = '0;
    logic  s_ready, ser_out, frame_start, frame_is_data, underrun;

    always #5 clk = ~clk;

    tx_ser dut (
        .clk           (clk),
        .rst           (rst),
        .bit_en        (bit_en),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .ser_out       (ser_out),
        .frame_start   (frame_start),
        .frame_is_data (frame_is_data),
        .underrun      (underrun)
    );

    int total = 0, bad = 0, cyc = 0;

    // Reference model: strobe count since reset selects the frame bit directly.
    int     m_n = 0;
    logic   m_pend = 1'b0;
    word_t  m_word = '0;
    frame_t m_frame = '0;
    logic   exp_ser = 1'b0, exp_fs = 1'b0, exp_fid = 1'b0, exp_ur = 1'b0;

    word_t src[$];

    typedef struct {
        frame_t bits;
        logic   is_data;
        logic   ur;
        int     start;
    } cap_t;
    cap_t frames[$];
    cap_t cur;
    int   cap_cnt = 0;
    logic cap_on = 1'b0;
    int   fs_high = 0, gate_viol = 0, acc_count = 0, last_acc_cyc = 0;
    logic prev_v = 1'b0, prev_rdy = 1'b0, prev_ser = 1'b0;
    word_t prev_d = '0;

    typedef struct {
        logic  r, e, v;
        word_t d;
        logic  rdy, ser, fs, fid, ur;
    } vec_t;
    vec_t vecs[14];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic modelStep(input logic r, input logic e, input logic v, input word_t d);
        logic bnd, acc;
        if (r) begin
            m_n = 0; m_pend = 1'b0; m_frame = '0;
            exp_ser = 1'b0; exp_fs = 1'b0; exp_fid = 1'b0; exp_ur = 1'b0;
        end else begin
            bnd    = e && (m_n % FRAME_W == 0);
            acc    = v && (!m_pend || bnd);
            exp_fs = bnd;
            exp_ur = bnd && !m_pend;
            if (bnd) begin
                m_frame = m_pend ? {SYNC_DATA, m_word} : {SYNC_IDLE, IDLE_WORD};
                exp_fid = m_pend;
            end
            if (e) begin
                exp_ser = m_frame[FRAME_W - 1 - (m_n % FRAME_W)];
                m_n++;
            end
            if (acc) begin
                m_pend = 1'b1;
                m_word = d;
            end else if (bnd) begin
                m_pend = 1'b0;
            end
        end
    endtask

    // One clock: offer the head of src, check s_ready, clock, check outputs, capture frames.
    task automatic applyStimulus(input logic r, input logic e);
        logic exp_rdy;
        rst     = r;
        bit_en  = e;
        s_valid = (src.size() > 0);
        s_data  = s_valid ? src[0] : word_t'($urandom);
        assert (!(prev_v && !prev_rdy) || (s_valid && s_data == prev_d))
            else $error("[TB] upstream dropped or changed an unaccepted word");
        #1;
        exp_rdy = !r && (!m_pend || (e && (m_n % FRAME_W == 0)));
        checkOutput("s_ready", s_ready, exp_rdy);
        prev_v   = s_valid;
        prev_rdy = s_ready;
        prev_d   = s_data;
        if (s_valid && s_ready) begin
            void'(src.pop_front());
            acc_count++;
            last_acc_cyc = cyc;
        end
        modelStep(r, e, s_valid, s_data);
        prev_ser = ser_out;
        @(posedge clk); #1;
        cyc++;
        checkOutput("ser_out", ser_out, exp_ser);
        checkOutput("frame_start", frame_start, exp_fs);
        checkOutput("frame_is_data", frame_is_data, exp_fid);
        checkOutput("underrun", underrun, exp_ur);
        if (!r && !e && ser_out !== prev_ser) gate_viol++;
        if (frame_start) fs_high++;
        if (r) begin
            cap_on = 1'b0;
        end else if (e) begin
            if (frame_start) begin
                cap_on      = 1'b1;
                cur.bits    = frame_t'(ser_out);
                cur.is_data = frame_is_data;
                cur.ur      = underrun;
                cur.start   = cyc;
                cap_cnt     = 1;
            end else if (cap_on) begin
                cur.bits = {cur.bits[FRAME_W-2:0], ser_out};
                cap_cnt++;
            end
            if (cap_on && cap_cnt == FRAME_W) begin
                frames.push_back(cur);
                cap_on = 1'b0;
            end
        end
    endtask

    task automatic doReset();
        repeat (3) applyStimulus(1'b1, 1'b1);
        frames.delete();
        cap_on = 1'b0; fs_high = 0; gate_viol = 0; acc_count = 0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        // r, e, v, d, | s_ready, ser_out, frame_start, frame_is_data, underrun
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 32'hA5A5_0F0F, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 32'h1111_1111, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        @(posedge clk); #1;
        for (int i = 0; i < 14; i++) begin
            rst = vecs[i].r; bit_en = vecs[i].e; s_valid = vecs[i].v; s_data = vecs[i].d;
            #1;
            checkOutput($sformatf("tbl%0d_s_ready", i), s_ready, vecs[i].rdy);
            @(posedge clk); #1;
            checkOutput($sformatf("tbl%0d_ser_out", i), ser_out, vecs[i].ser);
            checkOutput($sformatf("tbl%0d_frame_start", i), frame_start, vecs[i].fs);
            checkOutput($sformatf("tbl%0d_frame_is_data", i), frame_is_data, vecs[i].fid);
            checkOutput($sformatf("tbl%0d_underrun", i), underrun, vecs[i].ur);
        end
        s_valid = 1'b0;

        // Basic flow: idle frame with underrun, then the data frame.
        src.delete(); doReset();
        src.push_back(32'hA5A5_0F0F);
        repeat (68) applyStimulus(1'b0, 1'b1);
        checkOutput("basic_nframes", frames.size(), 2);
        if (frames.size() >= 2) begin
            checkOutput("basic_idle_bits", frames[0].bits, {SYNC_IDLE, IDLE_WORD});
            checkOutput("basic_idle_ur", frames[0].ur, 1'b1);
            checkOutput("basic_data_bits", frames[1].bits, {2'b01, 32'hA5A5_0F0F});
            checkOutput("basic_data_fid", frames[1].is_data, 1'b1);
            checkOutput("basic_period", frames[1].start - frames[0].start, 34);
        end

        // Back-to-back words: one idle frame, then three data frames without a gap.
        frames.delete(); acc_count = 0;
        src.push_back(32'h1); src.push_back(32'h2); src.push_back(32'h3);
        repeat (136) applyStimulus(1'b0, 1'b1);
        checkOutput("b2b_nframes", frames.size(), 4);
        checkOutput("b2b_accepts", acc_count, 3);
        if (frames.size() >= 4) begin
            for (int k = 1; k < 4; k++) begin
                checkOutput($sformatf("b2b_bits%0d", k), frames[k].bits, {SYNC_DATA, word_t'(k)});
                checkOutput($sformatf("b2b_fid%0d", k), frames[k].is_data, 1'b1);
            end
        end

        // Strobe gating: one strobe every 4 clocks.
        src.delete(); doReset();
        src.push_back(32'hDEAD_BEEF);
        for (int i = 0; i < 272; i++) applyStimulus(1'b0, (i % 4) == 0);
        checkOutput("gate_nframes", frames.size(), 2);
        checkOutput("gate_fs_width", fs_high, 2);
        checkOutput("gate_hold", gate_viol, 0);
        if (frames.size() >= 2) begin
            checkOutput("gate_span", frames[1].start - frames[0].start, 136);
            checkOutput("gate_bits", frames[1].bits, {2'b01, 32'hDEAD_BEEF});
        end

        // Boundary collision: a word arriving on the boundary misses that frame.
        src.delete(); doReset();
        repeat (34) applyStimulus(1'b0, 1'b1);
        src.push_back(32'h5A5A_1234);
        applyStimulus(1'b0, 1'b1);
        checkOutput("collide_accept", acc_count, 1);
        repeat (67) applyStimulus(1'b0, 1'b1);
        checkOutput("collide_nframes", frames.size(), 3);
        if (frames.size() >= 3) begin
            checkOutput("collide_idle", {frames[1].is_data, frames[1].ur}, 2'b01);
            checkOutput("collide_bits", frames[2].bits, {2'b01, 32'h5A5A_1234});
        end

        // Reset at bit 17 of a data frame with a second word held.
        src.delete(); doReset();
        src.push_back(32'hFFFF_FFFF); src.push_back(32'h1357_2468);
        repeat (52) applyStimulus(1'b0, 1'b1);
        checkOutput("mid_bit17", ser_out, 1'b1);
        checkOutput("mid_accepts", acc_count, 2);
        repeat (2) applyStimulus(1'b1, 1'b1);
        checkOutput("mid_rst_ser", ser_out, 1'b0);
        checkOutput("mid_rst_ready", s_ready, 1'b0);
        frames.delete();
        base = cyc;
        repeat (68) applyStimulus(1'b0, 1'b1);
        checkOutput("mid_nframes", frames.size(), 2);
        if (frames.size() >= 2) begin
            checkOutput("mid_first_start", frames[0].start - base, 1);
            checkOutput("mid_first_idle", {frames[0].is_data, frames[0].ur}, 2'b01);
            checkOutput("mid_word_lost", frames[1].is_data, 1'b0);
        end

        // Backpressure: second word waits 33 cycles and goes in on the boundary.
        src.delete(); doReset();
        src.push_back(32'h0BAD_CAFE); src.push_back(32'h600D_F00D);
        base = cyc;
        repeat (102) applyStimulus(1'b0, 1'b1);
        checkOutput("bp_accepts", acc_count, 2);
        checkOutput("bp_accept_cycle", last_acc_cyc - base, 34);
        checkOutput("bp_nframes", frames.size(), 3);
        if (frames.size() >= 3)
            checkOutput("bp_bits", frames[2].bits, {2'b01, 32'h600D_F00D});

        // Random traffic, strobes and occasional resets against the model.
        src.delete(); doReset();
        for (int i = 0; i < 4000; i++) begin
            if (src.size() == 0 && $urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) src.push_back(word_t'($urandom));
            end
            applyStimulus($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
